pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the RV32 if -> if_id -> id -> id_ex -> ex core.
//  Redirects the PC on taken branches (BNE from ex) and squashes wrong-path
//  instructions in if_id/id_ex for a programmable bubble count. Freezes the
//  front end on an external hold request (bus/debug), with a hold/ack handshake.
//  Keeps jump and stall performance counters.
// PARAMETERS
//  FLUSH_CYCLES  1         bubble cycles per taken jump, legal 1..7
//  ADDR_W        32        PC/jump address width
//  CNT_W         32        performance counter width
// PORTS
//  clk            in   1       core clock
//  rst            in   1       synchronous reset, active-low
//  jump_en_i      in   1       ex: branch taken this cycle
//  jump_addr_i    in   ADDR_W  ex: branch target
//  hold_req_i     in   1       external freeze request, level
//  hold_ack_o     out  1       pipeline frozen (registered)
//  pc_load_o      out  1       pc_reg: load pc_addr_o next edge
//  pc_addr_o      out  ADDR_W  redirect target
//  hold_pc_o      out  1       pc_reg: keep current PC
//  hold_if_id_o   out  1       if_id: keep contents
//  flush_if_id_o  out  1       if_id: load NOP (32'h00000013)
//  flush_id_ex_o  out  1       id_ex: load NOP, reg_wen=0
//  state_o        out  2       FSM state: 0=RUN 1=FLUSH 2=HOLD
//  jump_cnt_o     out  CNT_W   taken jumps since reset, wraps at 2^CNT_W
//  stall_cnt_o    out  CNT_W   HOLD-state cycles since reset, wraps
// BEHAVIOUR
//  - Reset (rst=0 at edge): state=RUN, flush counter=0, hold_ack_o=0,
//    both perf counters=0. While rst=0, all combinational outputs are 0
//    and pc_addr_o=0.
//  - Control outputs are Mealy (same cycle as the input), except
//    hold_ack_o and state_o, which are registered.
//  - RUN, jump_en_i=1:
//    - pc_load_o=1, pc_addr_o=jump_addr_i, flush_if_id_o=1,
//      flush_id_ex_o=1, all in the same cycle.
//    - jump_cnt_o+1.
//    - Next state is FLUSH with counter=FLUSH_CYCLES-1 when FLUSH_CYCLES>1,
//      otherwise RUN.
//    - Jump has priority over hold_req_i; a hold request waits in this case.
//  - FLUSH: flush_if_id_o=flush_id_ex_o=1 and pc_load_o=0. Counter
//    decrements each cycle; at counter==1 next state is RUN.
//    jump_en_i and hold_req_i are ignored (ex holds a bubble).
//  - RUN, jump_en_i=0, hold_req_i=1:
//    - hold_pc_o=hold_if_id_o=flush_id_ex_o=1 in the same cycle.
//    - Next state is HOLD.
//  - HOLD:
//    - hold_ack_o=1 in every cycle spent in HOLD (first cycle = one cycle
//      after the request was seen). stall_cnt_o+1 per HOLD cycle.
//    - hold_req_i=1: keep hold_pc_o/hold_if_id_o/flush_id_ex_o asserted.
//    - hold_req_i=0: all control outputs 0 that cycle; next state is RUN;
//      hold_ack_o falls at the next edge.
//    - jump_en_i is ignored.
//  - Never asserted together: pc_load_o with hold_pc_o;
//    hold_if_id_o with flush_if_id_o.
//  - Idle RUN (no jump, no hold): every control output is 0.
//  - Counters wrap modulo 2^CNT_W with no sticky flag.
//  - rst=0 mid-FLUSH or mid-HOLD aborts at the next edge to RUN with the
//    reset values above.
// TESTING
//  - Reset: hold rst=0 for 3 cycles with jump_en_i=1 and hold_req_i=1
//    -> all outputs 0, state_o=0, counters 0.
//  - FLUSH_CYCLES=1: jump_en_i=1, jump_addr_i=32'h40 for one cycle
//    -> same cycle pc_load_o=1, pc_addr_o=32'h40, both flushes=1;
//    next cycle all 0; jump_cnt_o=1.
//  - FLUSH_CYCLES=3: one-cycle jump -> flush outputs high for exactly
//    3 cycles; state_o sequence 1,1,0; the jump_en_i pulse in the second
//    flush cycle is ignored (jump_cnt_o stays 1).
//  - hold_req_i high for 4 cycles
//    -> hold_pc_o/hold_if_id_o high for 4 cycles;
//    hold_ack_o high cycles 2..5; stall_cnt_o=4.
//  - jump_en_i and hold_req_i both rising in the same cycle -> jump taken
//    first; HOLD entered on the first RUN cycle after the flush;
//    hold_ack_o one cycle later.
//  - rst=0 during HOLD -> next edge state_o=0, hold_ack_o=0.
//  - CNT_W=4: 17 jumps -> jump_cnt_o=1 (wrap).

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bundle between ex, the front-end registers and the pipeline sequencer.
// Carries jump/hold requests in and PC/if_id/id_ex steering plus perf counters out.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_req_i;
  logic              hold_ack_o;
  logic              pc_load_o;
  logic [ADDR_W-1:0] pc_addr_o;
  logic              hold_pc_o;
  logic              hold_if_id_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  jump_cnt_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport slave (
    input  jump_en_i, jump_addr_i, hold_req_i,
    output hold_ack_o, pc_load_o, pc_addr_o,
    output hold_pc_o, hold_if_id_o,
    output flush_if_id_o, flush_id_ex_o,
    output state_o, jump_cnt_o, stall_cnt_o
  );

  modport master (
    output jump_en_i, jump_addr_i, hold_req_i,
    input  hold_ack_o, pc_load_o, pc_addr_o,
    input  hold_pc_o, hold_if_id_o,
    input  flush_if_id_o, flush_id_ex_o,
    input  state_o, jump_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: branch redirect + wrong-path squash, external freeze
// with hold/ack handshake, jump and stall performance counters.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              ack_q;
  logic [CNT_W-1:0]  jcnt_q, scnt_q;

  logic              pc_load, hold_pc, hold_if_id;
  logic              flush_if_id, flush_id_ex;
  logic [ADDR_W-1:0] pc_addr;
  logic              jinc, sinc;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_load     = 1'b0;
    pc_addr     = '0;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jinc        = 1'b0;
    sinc        = 1'b0;
    if (rst) begin
      unique case (1'b1)
        state_q == RUN: begin
          // jump beats hold; a pending hold is seen after the flush
          if (bus.jump_en_i) begin
            pc_load     = 1'b1;
            pc_addr     = bus.jump_addr_i;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            jinc        = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FC_INIT;
            end
          end else if (bus.hold_req_i) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
            state_d     = HOLD;
          end
        end
        state_q == FLUSH: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          fcnt_d      = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = '0;
          end
        end
        state_q == HOLD: begin
          sinc = 1'b1;
          if (bus.hold_req_i) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      ack_q   <= 1'b0;
      jcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ack_q   <= (state_d == HOLD);
      if (jinc) jcnt_q <= jcnt_q + CNT_W'(1);
      if (sinc) scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_load_o     = pc_load;
  assign bus.pc_addr_o     = pc_addr;
  assign bus.hold_pc_o     = hold_pc;
  assign bus.hold_if_id_o  = hold_if_id;
  assign bus.flush_if_id_o = flush_if_id;
  assign bus.flush_id_ex_o = flush_id_ex;
  assign bus.hold_ack_o    = ack_q;
  assign bus.state_o       = state_q;
  assign bus.jump_cnt_o    = jcnt_q;
  assign bus.stall_cnt_o   = scnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with a single bubble cycle and
// a 32-bit counter, one with three bubble cycles and a 4-bit counter.
module tb_pipe_ctrl;

  typedef struct {
    logic        j;
    logic [31:0] a;
    logic        h;
    logic        pl;
    logic [31:0] pa;
    logic        hp;
    logic        hi;
    logic        fi;
    logic        fe;
    logic [1:0]  st;
    logic        ack;
    logic [31:0] jc;
    logic [31:0] sc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(32), .CNT_W(32)) ia ();
  pipe_ctrl_if #(.ADDR_W(32), .CNT_W(4))  ib ();

  pipe_ctrl #(.FLUSH_CYCLES(1), .ADDR_W(32), .CNT_W(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .ADDR_W(32), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  function automatic vec_t mk(
    logic j, logic [31:0] a, logic h,
    logic pl, logic [31:0] pa,
    logic hp, logic hi, logic fi, logic fe,
    logic [1:0] st, logic ack,
    logic [31:0] jc, logic [31:0] sc
  );
    vec_t v;
    v.j = j;   v.a = a;   v.h = h;
    v.pl = pl; v.pa = pa;
    v.hp = hp; v.hi = hi; v.fi = fi; v.fe = fe;
    v.st = st; v.ack = ack;
    v.jc = jc; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic check_a(input vec_t v, input string t);
    chk({t, ".pc_load"}, 32'(ia.pc_load_o), 32'(v.pl));
    if (v.pl) chk({t, ".pc_addr"}, ia.pc_addr_o, v.pa);
    chk({t, ".hold_pc"}, 32'(ia.hold_pc_o), 32'(v.hp));
    chk({t, ".hold_if_id"}, 32'(ia.hold_if_id_o), 32'(v.hi));
    chk({t, ".flush_if_id"}, 32'(ia.flush_if_id_o), 32'(v.fi));
    chk({t, ".flush_id_ex"}, 32'(ia.flush_id_ex_o), 32'(v.fe));
    chk({t, ".state"}, 32'(ia.state_o), 32'(v.st));
    chk({t, ".hold_ack"}, 32'(ia.hold_ack_o), 32'(v.ack));
    chk({t, ".jump_cnt"}, ia.jump_cnt_o, v.jc);
    chk({t, ".stall_cnt"}, ia.stall_cnt_o, v.sc);
    chk({t, ".excl"},
        32'((ia.pc_load_o & ia.hold_pc_o) |
            (ia.hold_if_id_o & ia.flush_if_id_o)), 32'd0);
  endtask

  task automatic check_b(input vec_t v, input string t);
    chk({t, ".pc_load"}, 32'(ib.pc_load_o), 32'(v.pl));
    if (v.pl) chk({t, ".pc_addr"}, ib.pc_addr_o, v.pa);
    chk({t, ".hold_pc"}, 32'(ib.hold_pc_o), 32'(v.hp));
    chk({t, ".hold_if_id"}, 32'(ib.hold_if_id_o), 32'(v.hi));
    chk({t, ".flush_if_id"}, 32'(ib.flush_if_id_o), 32'(v.fi));
    chk({t, ".flush_id_ex"}, 32'(ib.flush_id_ex_o), 32'(v.fe));
    chk({t, ".state"}, 32'(ib.state_o), 32'(v.st));
    chk({t, ".hold_ack"}, 32'(ib.hold_ack_o), 32'(v.ack));
    chk({t, ".jump_cnt"}, 32'(ib.jump_cnt_o), v.jc);
    chk({t, ".stall_cnt"}, 32'(ib.stall_cnt_o), v.sc);
    chk({t, ".excl"},
        32'((ib.pc_load_o & ib.hold_pc_o) |
            (ib.hold_if_id_o & ib.flush_if_id_o)), 32'd0);
  endtask

  task automatic run_a(input vec_t v, input string t);
    ia.jump_en_i = v.j; ia.jump_addr_i = v.a; ia.hold_req_i = v.h;
    @(negedge clk);
    check_a(v, t);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input vec_t v, input string t);
    ib.jump_en_i = v.j; ib.jump_addr_i = v.a; ib.hold_req_i = v.h;
    @(negedge clk);
    check_b(v, t);
    @(posedge clk); #1;
  endtask

  vec_t tv [14];
  vec_t z;

  initial begin
    //          j  a         h  pl pa        hp hi fi fe st ack jc sc
    tv[0]  = mk(1, 32'h40,   0, 1, 32'h40,   0, 0, 1, 1, 0, 0,  0, 0);
    tv[1]  = mk(0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0, 0,  1, 0);
    tv[2]  = mk(0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0, 0,  1, 0);
    tv[3]  = mk(0, 32'h0,    1, 0, 32'h0,    1, 1, 0, 1, 0, 0,  1, 0);
    tv[4]  = mk(0, 32'h0,    1, 0, 32'h0,    1, 1, 0, 1, 2, 1,  1, 0);
    tv[5]  = mk(0, 32'h0,    1, 0, 32'h0,    1, 1, 0, 1, 2, 1,  1, 1);
    tv[6]  = mk(0, 32'h0,    1, 0, 32'h0,    1, 1, 0, 1, 2, 1,  1, 2);
    tv[7]  = mk(0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 2, 1,  1, 3);
    tv[8]  = mk(0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0, 0,  1, 4);
    tv[9]  = mk(1, 32'h1234, 1, 1, 32'h1234, 0, 0, 1, 1, 0, 0,  1, 4);
    tv[10] = mk(0, 32'h0,    1, 0, 32'h0,    1, 1, 0, 1, 0, 0,  2, 4);
    tv[11] = mk(1, 32'hbeef, 1, 0, 32'h0,    1, 1, 0, 1, 2, 1,  2, 4);
    tv[12] = mk(0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 2, 1,  2, 5);
    tv[13] = mk(0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0, 0,  2, 6);

    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset held with both requests active
    rst = 1'b0;
    ia.jump_en_i = 1'b1; ia.jump_addr_i = 32'h40; ia.hold_req_i = 1'b1;
    ib.jump_en_i = 1'b1; ib.jump_addr_i = 32'h80; ib.hold_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.a_ctrl",
          32'({ia.pc_load_o, ia.hold_pc_o, ia.hold_if_id_o,
               ia.flush_if_id_o, ia.flush_id_ex_o}), 32'd0);
      chk("rst.a_addr", ia.pc_addr_o, 32'd0);
      chk("rst.b_ctrl",
          32'({ib.pc_load_o, ib.hold_pc_o, ib.hold_if_id_o,
               ib.flush_if_id_o, ib.flush_id_ex_o}), 32'd0);
      if (i > 0) begin
        check_a(mk(1, 32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.a");
        check_b(mk(1, 32'h80, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.b");
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    ia.jump_en_i = 1'b0; ia.jump_addr_i = '0; ia.hold_req_i = 1'b0;
    ib.jump_en_i = 1'b0; ib.jump_addr_i = '0; ib.hold_req_i = 1'b0;

    for (int i = 0; i < 14; i++)
      run_a(tv[i], $sformatf("a%0d", i));

    // three-cycle flush; jump pulse mid-flush is ignored
    run_b(mk(1, 32'h80, 0, 1, 32'h80, 0, 0, 1, 1, 0, 0, 0, 0), "f1");
    run_b(mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 1, 1, 1, 0, 1, 0), "f2");
    run_b(mk(1, 32'h99, 0, 0, 32'h0,  0, 0, 1, 1, 1, 0, 1, 0), "f3");
    run_b(mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 1, 0), "f4");

    // jump and hold together: hold waits for the flush to finish
    run_b(mk(1, 32'h200, 1, 1, 32'h200, 0, 0, 1, 1, 0, 0, 1, 0), "jh1");
    run_b(mk(0, 32'h0,   1, 0, 32'h0,   0, 0, 1, 1, 1, 0, 2, 0), "jh2");
    run_b(mk(0, 32'h0,   1, 0, 32'h0,   0, 0, 1, 1, 1, 0, 2, 0), "jh3");
    run_b(mk(0, 32'h0,   1, 0, 32'h0,   1, 1, 0, 1, 0, 0, 2, 0), "jh4");
    run_b(mk(0, 32'h0,   1, 0, 32'h0,   1, 1, 0, 1, 2, 1, 2, 0), "jh5");
    run_b(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 2, 1, 2, 1), "jh6");
    run_b(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 2, 2), "jh7");

    // reset in the middle of a hold
    run_b(mk(0, 32'h0, 1, 0, 32'h0, 1, 1, 0, 1, 0, 0, 2, 2), "rh1");
    run_b(mk(0, 32'h0, 1, 0, 32'h0, 1, 1, 0, 1, 2, 1, 2, 2), "rh2");
    rst = 1'b0;
    run_b(mk(0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 2, 1, 2, 3), "rh3");
    rst = 1'b1;
    run_b(z, "rh4");

    // 17 jumps on a 4-bit counter wrap to 1
    for (int k = 0; k < 17; k++) begin
      ib.jump_en_i = 1'b1; ib.jump_addr_i = 32'(k * 4);
      @(posedge clk); #1;
      ib.jump_en_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("wrap.jump_cnt", 32'(ib.jump_cnt_o), 32'd1);
    chk("wrap.state", 32'(ib.state_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
